uart_fifo_wb: RTL and testbench

Parametrised successor to the single-byte MiniUART WISHBONE slave. Full-duplex serial port with configurable data width, parity and stop bits, independent TX/RX bit-period divisors, and TX/RX FIFOs. Sits on the CPU bridge as a zero-wait WISHBONE peripheral.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/uart_fifo_wb_if.sv | 14 +
 rtl/uart_sync_fifo.sv | 40 ++++
 rtl/uart_fifo_wb.sv | 235 +++++++++++++++++++++++
 tb/tb_uart_fifo_wb.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state types for the uart_fifo_wb serial port.
package uart_pkg;

  localparam logic [2:0] OFF_DATA = 3'd0;
  localparam logic [2:0] OFF_LSR  = 3'd1;
  localparam logic [2:0] OFF_DIVR = 3'd2;
  localparam logic [2:0] OFF_DIVT = 3'd3;
  localparam logic [2:0] OFF_CTRL = 3'd4;
  localparam logic [2:0] OFF_IER  = 3'd5;

  localparam int LSR_RX_NE   = 0;
  localparam int LSR_OVR     = 1;
  localparam int LSR_PAR     = 2;
  localparam int LSR_FRM     = 3;
  localparam int LSR_TX_NF   = 5;
  localparam int LSR_TX_IDLE = 6;

  localparam int CTRL_PEN   = 0;
  localparam int CTRL_ODD   = 1;
  localparam int CTRL_STOP2 = 2;

  localparam int IER_RX  = 0;
  localparam int IER_TX  = 1;
  localparam int IER_ERR = 2;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;

endpackage

// File: rtl/uart_fifo_wb_if.sv
// Zero-wait WISHBONE-style register bus between the CPU bridge and the UART.
interface uart_fifo_wb_if;
  // stb is the request valid; the slave is always ready, so ack mirrors stb and
  // a transfer completes (side effects commit) on every clock edge where stb=1.
  logic [2:0]  off;
  logic [31:0] din;
  logic [31:0] dout;
  logic        stb;
  logic        we;
  logic        ack;

  modport master (output off, din, stb, we, input dout, ack);
  modport slave  (input off, din, stb, we, output dout, ack);
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; a push on full succeeds when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/uart_fifo_wb.sv
// Full-duplex UART with TX/RX FIFOs on a zero-wait register bus.
// Optional interrupt output and IER register when UART_IRQ_EN is defined.
module uart_fifo_wb
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_W      = 16,
  parameter int DIV_RST    = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  uart_fifo_wb_if.slave bus,
  input  logic         rxd,
  output logic         txd,
`ifdef UART_IRQ_EN
  output logic         irq,
`endif
  output tx_state_e    tx_state,
  output rx_state_e    rx_state
);
  logic [DIV_W-1:0]     divt, divr, tx_len, rx_len, rx_half;
  logic [DIV_W-1:0]     tx_cnt, rx_cnt;
  logic [2:0]           ctrl, tx_idx, rx_idx;
  logic [DATA_BITS-1:0] tx_sh, rx_sh, tx_head, rx_head;
  logic                 ovr, perr, ferr, tx_par, tx_stop2;
  logic                 wr, rd, lsr_rd, tx_push, tx_pop, rx_push, rx_pop;
  logic                 tx_full, tx_empty, rx_full, rx_empty, tx_idle;
  logic                 rx_s1, rx_s2, rx_s3, rx_fall, tx_done, rx_done;
  logic                 ovr_set, perr_set, ferr_set;
  logic [31:0]          lsr;
  tx_state_e            tx_next;
  rx_state_e            rx_next;

  assign bus.ack = bus.stb;
  assign wr      = bus.stb & bus.we;
  assign rd      = bus.stb & ~bus.we;
  assign lsr_rd  = rd && (bus.off == OFF_LSR);
  assign rx_pop  = rd && (bus.off == OFF_DATA) && !rx_empty;
  assign tx_push = wr && (bus.off == OFF_DATA) && !tx_full;
  assign tx_idle = tx_empty && (tx_state == TX_IDLE);

  // Bit period is max(DIV,2); counters hold period-1 and count down to 0.
  assign tx_len  = (divt < DIV_W'(2)) ? DIV_W'(1) : divt - DIV_W'(1);
  assign rx_len  = (divr < DIV_W'(2)) ? DIV_W'(1) : divr - DIV_W'(1);
  assign rx_half = ((divr < DIV_W'(2)) ? DIV_W'(1) : (divr >> 1)) - DIV_W'(1);
  assign tx_done = (tx_cnt == '0);
  assign rx_done = (rx_cnt == '0);
  assign rx_fall = rx_s3 & ~rx_s2;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
    .wdata(bus.din[DATA_BITS-1:0]), .full(tx_full), .empty(tx_empty), .head(tx_head)
  );

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
    .wdata(rx_sh), .full(rx_full), .empty(rx_empty), .head(rx_head)
  );

  // Configuration registers and sticky error flags (set wins over LSR-read clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divt <= DIV_W'(DIV_RST);
      divr <= DIV_W'(DIV_RST);
      ctrl <= '0;
      ovr  <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (wr) begin
        case (bus.off)
          OFF_DIVR: divr <= bus.din[DIV_W-1:0];
          OFF_DIVT: divt <= bus.din[DIV_W-1:0];
          OFF_CTRL: ctrl <= bus.din[2:0];
          default:  ;
        endcase
      end
      ovr  <= ovr_set  | (ovr  & ~lsr_rd);
      perr <= perr_set | (perr & ~lsr_rd);
      ferr <= ferr_set | (ferr & ~lsr_rd);
    end
  end

  // TX state register and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_sh    <= '0;
      tx_par   <= 1'b0;
      tx_stop2 <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_pop) begin
        tx_sh    <= tx_head;
        tx_par   <= (^tx_head) ^ ctrl[CTRL_ODD];
        tx_cnt   <= tx_len;
        tx_idx   <= '0;
        tx_stop2 <= 1'b0;
      end else if (tx_state != TX_IDLE) begin
        if (tx_done) begin
          tx_cnt <= tx_len;
          if (tx_state == TX_DATA) begin
            tx_sh  <= tx_sh >> 1;
            tx_idx <= tx_idx + 3'd1;
          end
          if (tx_state == TX_STOP) tx_stop2 <= 1'b1;
        end else begin
          tx_cnt <= tx_cnt - DIV_W'(1);
        end
      end
    end
  end

  // TX next state; a pending byte at the end of STOP starts the next frame with no gap.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    case (tx_state)
      TX_IDLE:   if (!tx_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
      TX_START:  if (tx_done) tx_next = TX_DATA;
      TX_DATA:   if (tx_done && tx_idx == 3'(DATA_BITS-1))
                   tx_next = ctrl[CTRL_PEN] ? TX_PARITY : TX_STOP;
      TX_PARITY: if (tx_done) tx_next = TX_STOP;
      TX_STOP:   if (tx_done && (!ctrl[CTRL_STOP2] || tx_stop2)) begin
                   if (!tx_empty) begin tx_pop = 1'b1; tx_next = TX_START; end
                   else tx_next = TX_IDLE;
                 end
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_sh[0];
      TX_PARITY: txd = tx_par;
      default:   txd = 1'b1;
    endcase
  end

  // RX synchroniser (reset to idle-high), state register and datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_sh    <= '0;
    end else begin
      rx_s1    <= rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) begin
        if (rx_fall) rx_cnt <= rx_half;
      end else if (rx_done) begin
        rx_cnt <= rx_len;
        if (rx_state == RX_START) rx_idx <= '0;
        if (rx_state == RX_DATA) begin
          rx_sh  <= {rx_s2, rx_sh[DATA_BITS-1:1]};
          rx_idx <= rx_idx + 3'd1;
        end
      end else begin
        rx_cnt <= rx_cnt - DIV_W'(1);
      end
    end
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:   if (rx_fall) rx_next = RX_START;
      RX_START:  if (rx_done) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:   if (rx_done && rx_idx == 3'(DATA_BITS-1))
                   rx_next = ctrl[CTRL_PEN] ? RX_PARITY : RX_STOP;
      RX_PARITY: if (rx_done) rx_next = RX_STOP;
      RX_STOP:   if (rx_done) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_push  = (rx_state == RX_STOP) && rx_done;
    ferr_set = rx_push && !rx_s2;
    ovr_set  = rx_push && rx_full && !rx_pop;
    perr_set = (rx_state == RX_PARITY) && rx_done &&
               (rx_s2 != ((^rx_sh) ^ ctrl[CTRL_ODD]));
  end

  always_comb begin
    lsr              = '0;
    lsr[LSR_RX_NE]   = ~rx_empty;
    lsr[LSR_OVR]     = ovr;
    lsr[LSR_PAR]     = perr;
    lsr[LSR_FRM]     = ferr;
    lsr[LSR_TX_NF]   = ~tx_full;
    lsr[LSR_TX_IDLE] = tx_idle;
  end

`ifdef UART_IRQ_EN
  logic [2:0] ier;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ier <= '0;
      irq <= 1'b0;
    end else begin
      if (wr && bus.off == OFF_IER) ier <= bus.din[2:0];
      irq <= (ier[IER_RX] & ~rx_empty) | (ier[IER_TX] & tx_idle) |
             (ier[IER_ERR] & (ovr | perr | ferr));
    end
  end
`endif

  always_comb begin
    bus.dout = '0;
    case (bus.off)
      OFF_DATA: if (!rx_empty) bus.dout[DATA_BITS-1:0] = rx_head;
      OFF_LSR:  bus.dout = lsr;
      OFF_DIVR: bus.dout[DIV_W-1:0] = divr;
      OFF_DIVT: bus.dout[DIV_W-1:0] = divt;
      OFF_CTRL: bus.dout[2:0] = ctrl;
`ifdef UART_IRQ_EN
      OFF_IER:  bus.dout[2:0] = ier;
`endif
      default:  ;
    endcase
  end
endmodule

// File: tb/tb_uart_fifo_wb.sv
// Directed bench for uart_fifo_wb: register access, TX framing/FIFO, RX parity/overrun/framing, reset.
module tb_uart_fifo_wb;
  import uart_pkg::*;

  logic      clk, rst_n, rxd, txd;
  tx_state_e tx_state;
  rx_state_e rx_state;
`ifdef UART_IRQ_EN
  logic      irq;
`endif
  int        checks = 0;
  int        failures = 0;
  logic [31:0] r, r2;

  uart_fifo_wb_if bif();

  uart_fifo_wb dut (
    .clk(clk), .rst_n(rst_n), .bus(bif), .rxd(rxd), .txd(txd),
`ifdef UART_IRQ_EN
    .irq(irq),
`endif
    .tx_state(tx_state), .rx_state(rx_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [31:0] data);
    @(negedge clk);
    bif.stb = 1'b1; bif.we = 1'b1; bif.off = off; bif.din = data;
    @(negedge clk);
    bif.stb = 1'b0; bif.we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [31:0] data);
    @(negedge clk);
    bif.stb = 1'b1; bif.we = 1'b0; bif.off = off;
    #1;
    data = bif.dout;
    check("ack", 32'(bif.ack), 32'd1);
    @(negedge clk);
    bif.stb = 1'b0;
  endtask

  task automatic wait_tx_start();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (txd !== 1'b0 && n < 300);
    check("tx_start_seen", 32'(txd), 32'd0);
  endtask

  // Entered on the first negedge of a frame; leaves on the first negedge after it.
  task automatic tx_frame(input logic [7:0] data, input int div, input bit search, input bit mon);
    logic [9:0] bits;
    bits = {1'b1, data, 1'b0};
    if (search) wait_tx_start();
    for (int k = 0; k < 10; k++) begin
      repeat (div / 2) @(negedge clk);
      check($sformatf("tx_%0h_bit%0d", data, k), 32'(txd), 32'(bits[k]));
      if (mon) check("lsr_tx_busy", 32'(bif.dout[6]), 32'd0);
      repeat (div - div / 2) @(negedge clk);
    end
  endtask

  task automatic rx_bit(input logic v, input int n);
    rxd = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_frame(input logic [7:0] d, input int div, input bit pen, input bit pbit,
                          input bit stop);
    rx_bit(1'b0, div);
    for (int k = 0; k < 8; k++) rx_bit(d[k], div);
    if (pen) rx_bit(pbit, div);
    rx_bit(stop, div);
    rx_bit(1'b1, 2 * div);
  endtask

  initial begin
    rst_n = 1'b0; rxd = 1'b1;
    bif.stb = 1'b0; bif.we = 1'b0; bif.off = '0; bif.din = '0;
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_ack", 32'(bif.ack), 32'd0);
    rst_n = 1'b1;

    // Reset register state and empty-FIFO read
    bus_read(OFF_LSR, r);  check("rst_lsr", r, 32'h60);
    bus_read(OFF_DATA, r); check("empty_data", r, 32'h0);
    bus_read(OFF_LSR, r);  check("lsr_after_empty_rd", r, 32'h60);
    bus_read(OFF_DIVT, r); check("rst_divt", r, 32'd16);
    bus_read(OFF_DIVR, r); check("rst_divr", r, 32'd16);
    bus_read(OFF_CTRL, r); check("rst_ctrl", r, 32'd0);
    bus_write(3'd7, 32'hFFFF_FFFF);
    bus_read(3'd7, r);     check("off7_zero", r, 32'd0);
    bus_read(3'd6, r);     check("off6_zero", r, 32'd0);
    bus_read(3'd5, r);     check("off5_zero", r, 32'd0);

    // Single TX frame 0x12 at 9 clk/bit, LSR idle bit watched passively
    bus_write(OFF_DIVT, 32'd9);
    bus_read(OFF_DIVT, r); check("divt_wr", r, 32'd9);
    bus_write(OFF_DATA, 32'h12);
    bif.off = OFF_LSR;
    tx_frame(8'h12, 9, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    bus_read(OFF_LSR, r); check("lsr_tx_done", r, 32'h60);

    // TX FIFO fill while busy: 0xA5 dropped, remaining frames back to back
    fork
      begin
        bus_write(OFF_DATA, 32'h5A);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) bus_write(OFF_DATA, 32'hA1 + 32'(i));
        bus_read(OFF_LSR, r2); check("lsr_tx_full", r2, 32'h00);
      end
      begin
        wait_tx_start();
        tx_frame(8'h5A, 9, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tx_frame(8'hA1 + 8'(i), 9, 1'b0, 1'b0);
      end
    join
    repeat (3) @(negedge clk);
    bus_read(OFF_LSR, r); check("lsr_a5_dropped", r, 32'h60);

    // RX with even parity: good then bad parity
    bus_write(OFF_DIVR, 32'd16);
    bus_write(OFF_CTRL, 32'h1);
    rx_frame(8'h55, 16, 1'b1, 1'b0, 1'b1);
    bus_read(OFF_LSR, r);  check("rx_par_ok_lsr", r, 32'h61);
    bus_read(OFF_DATA, r); check("rx_par_ok_data", r, 32'h55);
    bus_read(OFF_LSR, r);  check("rx_drained_lsr", r, 32'h60);
    rx_frame(8'h55, 16, 1'b1, 1'b1, 1'b1);
    bus_read(OFF_LSR, r);  check("rx_par_bad_lsr", r, 32'h65);
    bus_read(OFF_LSR, r);  check("rx_par_cleared", r, 32'h61);
    bus_read(OFF_DATA, r); check("rx_par_bad_data", r, 32'h55);

    // Overrun: five frames into a four-entry FIFO
    bus_write(OFF_CTRL, 32'h0);
    for (int i = 0; i < 5; i++) rx_frame(8'(8'h11 * (i + 1)), 16, 1'b0, 1'b0, 1'b1);
    bus_read(OFF_LSR, r); check("rx_ovr_lsr", r, 32'h63);
    for (int i = 0; i < 4; i++) begin
      bus_read(OFF_DATA, r);
      check($sformatf("rx_ovr_data%0d", i), r, 32'(8'h11 * (i + 1)));
    end
    bus_read(OFF_LSR, r); check("rx_ovr_cleared", r, 32'h60);

    // Two-cycle low glitch must not produce a frame
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_idle", 32'(rx_state), 32'(RX_IDLE));
    bus_read(OFF_LSR, r); check("glitch_lsr", r, 32'h60);

    // Framing error: stop bit low, frame still stored
    rx_frame(8'h3C, 16, 1'b0, 1'b0, 1'b0);
    bus_read(OFF_LSR, r);  check("frm_lsr", r, 32'h69);
    bus_read(OFF_DATA, r); check("frm_data", r, 32'h3C);
    bus_read(OFF_LSR, r);  check("frm_cleared", r, 32'h60);

    // Reset in the middle of a TX frame with bytes still queued
    bus_write(OFF_DATA, 32'h00);
    bus_write(OFF_DATA, 32'hFF);
    bus_write(OFF_DATA, 32'hFF);
    repeat (16) @(negedge clk);
    check("midtx_txd_low", 32'(txd), 32'd0);
    check("midtx_state", 32'(tx_state), 32'(TX_DATA));
    rst_n = 1'b0;
    #1;
    check("rst_async_txd", 32'(txd), 32'd1);
    check("rst_async_state", 32'(tx_state), 32'(TX_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(OFF_LSR, r);  check("post_rst_lsr", r, 32'h60);
    bus_read(OFF_DIVT, r); check("post_rst_divt", r, 32'd16);
    repeat (30) @(negedge clk);
    check("post_rst_txd_idle", 32'(txd), 32'd1);
    bus_read(OFF_LSR, r);  check("post_rst_fifo_lost", r, 32'h60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
